// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order commit buffer sitting between the dispatcher / CDB and
//   the register file. One tag is handed out per dispatched instruction, CDB
//   results are captured per tag, and the head entry retires (one per cycle)
//   once its result is in the array. A retiring mispredicted branch triggers a
//   one-cycle FLUSH that clears the buffer and redirects fetch.
//
// Ports
//   clk_in, rst_in, rdy_in           clock, async active-high reset, global enable
//   dispatcher_rob_*                 allocation request (rd, kind) and two
//                                    operand tag queries (qs / qt)
//   rob_dispatcher_*                 full flag, next tag, query ready / value
//   cdb_*                            result broadcast (tag, value, mispredict,
//                                    redirect target)
//   rob_regfile_*                    registered commit write port and busy clear
//   rob_lsb_*                        registered store-commit pulse and tag
//   rob_fetcher_*                    registered flush strobe and redirect PC
// ----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5,
    parameter int ID_WIDTH  = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 dispatcher_rob_en_in,
    input  logic [REG_WIDTH-1:0] dispatcher_rob_rd_in,
    input  logic [1:0]           dispatcher_rob_kind_in,
    output logic                 rob_dispatcher_full_out,
    output logic [ROB_WIDTH-1:0] rob_dispatcher_tag_out,
    input  logic [ROB_WIDTH-1:0] dispatcher_rob_qs_in,
    output logic                 rob_dispatcher_qs_ready_out,
    output logic [ID_WIDTH-1:0]  rob_dispatcher_qs_value_out,
    input  logic [ROB_WIDTH-1:0] dispatcher_rob_qt_in,
    output logic                 rob_dispatcher_qt_ready_out,
    output logic [ID_WIDTH-1:0]  rob_dispatcher_qt_value_out,
    input  logic                 cdb_en_in,
    input  logic [ROB_WIDTH-1:0] cdb_tag_in,
    input  logic [ID_WIDTH-1:0]  cdb_value_in,
    input  logic                 cdb_mispredict_in,
    input  logic [ID_WIDTH-1:0]  cdb_target_in,
    output logic                 rob_regfile_en_out,
    output logic [REG_WIDTH-1:0] rob_regfile_d_out,
    output logic [ID_WIDTH-1:0]  rob_regfile_value_out,
    output logic [ROB_WIDTH-1:0] rob_regfile_h_out,
    output logic                 rob_regfile_rst_out,
    output logic                 rob_lsb_commit_out,
    output logic [ROB_WIDTH-1:0] rob_lsb_tag_out,
    output logic                 rob_fetcher_flush_out,
    output logic [ID_WIDTH-1:0]  rob_fetcher_pc_out
);

    localparam int DEPTH = 32'sd1 << ROB_WIDTH;

    localparam logic [ROB_WIDTH:0]   DEPTH_CNT = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0]   ONE_CNT   = {{ROB_WIDTH{1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH-1:0] ONE_TAG   = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0]     ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] KIND_BRANCH = 2'd1;
    localparam logic [1:0] KIND_STORE  = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rob_state_t;

    // Entry payload; kept without reset because nothing reads it unless the
    // matching ready bit (which is reset) is set.
    logic [REG_WIDTH-1:0] rd_mem_r     [DEPTH];
    logic [1:0]           kind_mem_r   [DEPTH];
    logic [ID_WIDTH-1:0]  value_mem_r  [DEPTH];
    logic [ID_WIDTH-1:0]  target_mem_r [DEPTH];

    logic [DEPTH-1:0]     ready_r;
    logic [DEPTH-1:0]     mis_r;
    logic [ROB_WIDTH-1:0] head_r;
    logic [ROB_WIDTH-1:0] tail_r;
    logic [ROB_WIDTH:0]   count_r;
    rob_state_t           state_r;

    logic                 regfile_en_r;
    logic [REG_WIDTH-1:0] regfile_d_r;
    logic [ID_WIDTH-1:0]  regfile_value_r;
    logic [ROB_WIDTH-1:0] regfile_h_r;
    logic                 regfile_rst_r;
    logic                 lsb_commit_r;
    logic [ROB_WIDTH-1:0] lsb_tag_r;
    logic                 flush_r;
    logic [ID_WIDTH-1:0]  fetch_pc_r;
    logic [ID_WIDTH-1:0]  flush_pc_r;

    logic                 full_s;
    logic                 alloc_s;
    logic                 cdb_wr_s;
    logic                 commit_s;
    logic [1:0]           head_kind_s;
    logic                 flush_req_s;
    logic [DEPTH-1:0]     cdb_mask_s;
    logic [DEPTH-1:0]     pop_mask_s;
    logic [DEPTH-1:0]     alloc_mask_s;
    logic [DEPTH-1:0]     ready_next_s;
    logic [DEPTH-1:0]     mis_next_s;
    logic [ROB_WIDTH:0]   count_next_s;
    rob_state_t           state_next_s;
    logic                 qs_hit_s;
    logic                 qt_hit_s;

    // Full also blocks allocation during the flush cycle so nothing survives it.
    assign full_s      = (count_r == DEPTH_CNT) | (state_r == ST_FLUSH);
    assign alloc_s     = dispatcher_rob_en_in & ~full_s;
    assign cdb_wr_s    = cdb_en_in & (state_r == ST_RUN);
    // Uses the registered ready bit, so a CDB write never retires on the same edge.
    assign commit_s    = (state_r == ST_RUN) & (count_r != {(ROB_WIDTH+1){1'b0}}) & ready_r[head_r];
    assign head_kind_s = kind_mem_r[head_r];
    assign flush_req_s = commit_s & mis_r[head_r] & (head_kind_s == KIND_BRANCH);

    assign cdb_mask_s   = cdb_wr_s ? (ONE_HOT0 << cdb_tag_in) : {DEPTH{1'b0}};
    assign pop_mask_s   = commit_s ? (ONE_HOT0 << head_r)     : {DEPTH{1'b0}};
    assign alloc_mask_s = alloc_s  ? (ONE_HOT0 << tail_r)     : {DEPTH{1'b0}};

    // A fresh allocation always wins, leaving its slot not-ready and not-mispredicted.
    assign ready_next_s = (ready_r | cdb_mask_s) & ~pop_mask_s & ~alloc_mask_s;
    assign mis_next_s   = ((mis_r & ~cdb_mask_s) | (cdb_mispredict_in ? cdb_mask_s : {DEPTH{1'b0}}))
                          & ~alloc_mask_s;

    // Operand queries: a result on the CDB this cycle bypasses the array.
    assign qs_hit_s = cdb_en_in & (cdb_tag_in == dispatcher_rob_qs_in);
    assign qt_hit_s = cdb_en_in & (cdb_tag_in == dispatcher_rob_qt_in);

    assign rob_dispatcher_full_out     = full_s;
    assign rob_dispatcher_tag_out      = tail_r;
    assign rob_dispatcher_qs_ready_out = ready_r[dispatcher_rob_qs_in] | qs_hit_s;
    assign rob_dispatcher_qt_ready_out = ready_r[dispatcher_rob_qt_in] | qt_hit_s;
    assign rob_dispatcher_qs_value_out = qs_hit_s ? cdb_value_in :
                                         (ready_r[dispatcher_rob_qs_in] ? value_mem_r[dispatcher_rob_qs_in]
                                                                        : {ID_WIDTH{1'b0}});
    assign rob_dispatcher_qt_value_out = qt_hit_s ? cdb_value_in :
                                         (ready_r[dispatcher_rob_qt_in] ? value_mem_r[dispatcher_rob_qt_in]
                                                                        : {ID_WIDTH{1'b0}});

    assign rob_regfile_en_out    = regfile_en_r;
    assign rob_regfile_d_out     = regfile_d_r;
    assign rob_regfile_value_out = regfile_value_r;
    assign rob_regfile_h_out     = regfile_h_r;
    assign rob_regfile_rst_out   = regfile_rst_r;
    assign rob_lsb_commit_out    = lsb_commit_r;
    assign rob_lsb_tag_out       = lsb_tag_r;
    assign rob_fetcher_flush_out = flush_r;
    assign rob_fetcher_pc_out    = fetch_pc_r;

    // Occupancy next value: simultaneous alloc and commit leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        if (alloc_s && !commit_s) begin
            count_next_s = count_r + ONE_CNT;
        end else if (commit_s && !alloc_s) begin
            count_next_s = count_r - ONE_CNT;
        end else begin
            count_next_s = count_r;
        end
    end

    // FSM next state: a retiring mispredicted branch enters FLUSH for exactly one cycle.
    always_comb begin
        state_next_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (flush_req_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Entry payload capture from allocation and CDB.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (cdb_wr_s) begin
                value_mem_r[cdb_tag_in]  <= cdb_value_in;
                target_mem_r[cdb_tag_in] <= cdb_target_in;
            end
            if (alloc_s) begin
                rd_mem_r[tail_r]   <= dispatcher_rob_rd_in;
                kind_mem_r[tail_r] <= dispatcher_rob_kind_in;
            end
        end
    end

    // Pointers, status bits, FSM state and all registered commit/flush outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ready_r         <= {DEPTH{1'b0}};
            mis_r           <= {DEPTH{1'b0}};
            head_r          <= {ROB_WIDTH{1'b0}};
            tail_r          <= {ROB_WIDTH{1'b0}};
            count_r         <= {(ROB_WIDTH+1){1'b0}};
            state_r         <= ST_RUN;
            regfile_en_r    <= 1'b0;
            regfile_d_r     <= {REG_WIDTH{1'b0}};
            regfile_value_r <= {ID_WIDTH{1'b0}};
            regfile_h_r     <= {ROB_WIDTH{1'b0}};
            regfile_rst_r   <= 1'b0;
            lsb_commit_r    <= 1'b0;
            lsb_tag_r       <= {ROB_WIDTH{1'b0}};
            flush_r         <= 1'b0;
            fetch_pc_r      <= {ID_WIDTH{1'b0}};
            flush_pc_r      <= {ID_WIDTH{1'b0}};
        end else if (rdy_in) begin
            // Strobes are single-cycle unless re-asserted below.
            regfile_en_r  <= 1'b0;
            lsb_commit_r  <= 1'b0;
            regfile_rst_r <= 1'b0;
            flush_r       <= 1'b0;
            state_r       <= state_next_s;
            if (state_r == ST_FLUSH) begin
                ready_r       <= {DEPTH{1'b0}};
                mis_r         <= {DEPTH{1'b0}};
                head_r        <= {ROB_WIDTH{1'b0}};
                tail_r        <= {ROB_WIDTH{1'b0}};
                count_r       <= {(ROB_WIDTH+1){1'b0}};
                regfile_rst_r <= 1'b1;
                flush_r       <= 1'b1;
                fetch_pc_r    <= flush_pc_r;
            end else begin
                ready_r <= ready_next_s;
                mis_r   <= mis_next_s;
                count_r <= count_next_s;
                if (alloc_s) begin
                    tail_r <= tail_r + ONE_TAG;
                end
                if (commit_s) begin
                    head_r <= head_r + ONE_TAG;
                    if (head_kind_s == KIND_STORE) begin
                        lsb_commit_r <= 1'b1;
                        lsb_tag_r    <= head_r;
                    end else begin
                        regfile_en_r    <= 1'b1;
                        regfile_d_r     <= rd_mem_r[head_r];
                        regfile_value_r <= value_mem_r[head_r];
                        regfile_h_r     <= head_r;
                    end
                    // Target is latched now because the head pointer moves on this edge.
                    if (flush_req_s) begin
                        flush_pc_r <= target_mem_r[head_r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        d_en;
    logic [4:0]  d_rd;
    logic [1:0]  d_kind;
    logic [3:0]  qs, qt;
    logic        c_en;
    logic [3:0]  c_tag;
    logic [31:0] c_val;
    logic        c_mis;
    logic [31:0] c_tgt;

    logic        full;
    logic [3:0]  tag;
    logic        qs_rdy, qt_rdy;
    logic [31:0] qs_val, qt_val;
    logic        rf_en;
    logic [4:0]  rf_d;
    logic [31:0] rf_val;
    logic [3:0]  rf_h;
    logic        rf_rst;
    logic        lsb_c;
    logic [3:0]  lsb_tag;
    logic        fl;
    logic [31:0] fl_pc;

    reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5), .ID_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatcher_rob_en_in(d_en), .dispatcher_rob_rd_in(d_rd), .dispatcher_rob_kind_in(d_kind),
        .rob_dispatcher_full_out(full), .rob_dispatcher_tag_out(tag),
        .dispatcher_rob_qs_in(qs), .rob_dispatcher_qs_ready_out(qs_rdy), .rob_dispatcher_qs_value_out(qs_val),
        .dispatcher_rob_qt_in(qt), .rob_dispatcher_qt_ready_out(qt_rdy), .rob_dispatcher_qt_value_out(qt_val),
        .cdb_en_in(c_en), .cdb_tag_in(c_tag), .cdb_value_in(c_val),
        .cdb_mispredict_in(c_mis), .cdb_target_in(c_tgt),
        .rob_regfile_en_out(rf_en), .rob_regfile_d_out(rf_d), .rob_regfile_value_out(rf_val),
        .rob_regfile_h_out(rf_h), .rob_regfile_rst_out(rf_rst),
        .rob_lsb_commit_out(lsb_c), .rob_lsb_tag_out(lsb_tag),
        .rob_fetcher_flush_out(fl), .rob_fetcher_pc_out(fl_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- reference model: ordered queue of in-flight instructions
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [1:0]  kind;
        bit          ready;
        logic [31:0] value;
        bit          mis;
        logic [31:0] target;
    } ment_t;

    ment_t       m_q[$];
    int          m_next_tag;
    bit          m_flush_pend;
    logic [31:0] m_flush_pc;
    logic        e_rf_en, e_rst, e_lsb, e_flush;
    logic [4:0]  e_d;
    logic [31:0] e_val, e_pc;
    logic [3:0]  e_h, e_lsb_tag;

    // values seen just before the most recent clock edge
    logic        pre_full, pre_qs_rdy, pre_qt_rdy;
    logic [3:0]  pre_tag;
    logic [31:0] pre_qs_val, pre_qt_val;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic        ce;
        logic [3:0]  ct;
        logic [31:0] cv;
        logic [3:0]  exp_tag;
        logic        exp_rf_en;
        logic [4:0]  exp_d;
        logic [31:0] exp_val;
        logic [3:0]  exp_h;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_next_tag = 0; m_flush_pend = 0; m_flush_pc = 32'h0;
        e_rf_en = 1'b0; e_rst = 1'b0; e_lsb = 1'b0; e_flush = 1'b0;
        e_d = 5'h0; e_val = 32'h0; e_pc = 32'h0; e_h = 4'h0; e_lsb_tag = 4'h0;
    endtask

    task automatic m_query(input logic [3:0] t, output logic r, output logic [31:0] v);
        r = 1'b0; v = 32'h0;
        foreach (m_q[i]) if (m_q[i].tag == int'(t) && m_q[i].ready) begin r = 1'b1; v = m_q[i].value; end
        if (c_en && c_tag == t) begin r = 1'b1; v = c_val; end
    endtask

    task automatic m_edge();
        ment_t h;
        ment_t n;
        bit    do_commit;
        bit    was_full;
        if (!rdy_in) return;
        e_rf_en = 1'b0; e_lsb = 1'b0; e_rst = 1'b0; e_flush = 1'b0;
        if (m_flush_pend) begin
            m_q.delete(); m_next_tag = 0;
            e_rst = 1'b1; e_flush = 1'b1; e_pc = m_flush_pc; m_flush_pend = 0;
            return;
        end
        was_full  = (m_q.size() == 16);
        do_commit = (m_q.size() > 0) && m_q[0].ready;
        if (do_commit) h = m_q[0];
        if (c_en) foreach (m_q[i]) if (m_q[i].tag == int'(c_tag)) begin
            m_q[i].ready = 1; m_q[i].value = c_val; m_q[i].mis = c_mis; m_q[i].target = c_tgt;
        end
        if (do_commit) begin
            void'(m_q.pop_front());
            if (h.kind == 2'd2) begin
                e_lsb = 1'b1; e_lsb_tag = 4'(h.tag);
            end else begin
                e_rf_en = 1'b1; e_d = h.rd; e_val = h.value; e_h = 4'(h.tag);
            end
            if (h.kind == 2'd1 && h.mis) begin m_flush_pend = 1; m_flush_pc = h.target; end
        end
        if (d_en && !was_full) begin
            n.tag = m_next_tag; n.rd = d_rd; n.kind = d_kind; n.ready = 0;
            n.value = 32'h0; n.mis = 0; n.target = 32'h0;
            m_q.push_back(n);
            m_next_tag = (m_next_tag + 1) % 16;
        end
    endtask

    // one clock: combinational checks before the edge, registered checks after
    task automatic cycle();
        logic        r;
        logic [31:0] v;
        @(negedge clk_in); #1;
        pre_full = full; pre_tag = tag;
        pre_qs_rdy = qs_rdy; pre_qs_val = qs_val; pre_qt_rdy = qt_rdy; pre_qt_val = qt_val;
        chk("full", 32'(full), 32'((m_q.size() == 16) || m_flush_pend));
        chk("tag_out", 32'(tag), 32'(m_next_tag));
        m_query(qs, r, v);
        chk("qs_ready", 32'(qs_rdy), 32'(r));
        chk("qs_value", qs_val, v);
        m_query(qt, r, v);
        chk("qt_ready", 32'(qt_rdy), 32'(r));
        chk("qt_value", qt_val, v);
        @(posedge clk_in);
        m_edge();
        #1;
        chk("rf_en", 32'(rf_en), 32'(e_rf_en));
        chk("rf_d", 32'(rf_d), 32'(e_d));
        chk("rf_value", rf_val, e_val);
        chk("rf_h", 32'(rf_h), 32'(e_h));
        chk("rf_rst", 32'(rf_rst), 32'(e_rst));
        chk("lsb_commit", 32'(lsb_c), 32'(e_lsb));
        chk("lsb_tag", 32'(lsb_tag), 32'(e_lsb_tag));
        chk("flush", 32'(fl), 32'(e_flush));
        chk("flush_pc", fl_pc, e_pc);
    endtask

    task automatic drive(input logic en, input logic [4:0] rd, input logic [1:0] kind,
                         input logic ce, input logic [3:0] ct, input logic [31:0] cv,
                         input logic cm, input logic [31:0] tg);
        d_en = en; d_rd = rd; d_kind = kind;
        c_en = ce; c_tag = ct; c_val = cv; c_mis = cm; c_tgt = tg;
        cycle();
        d_en = 1'b0; c_en = 1'b0; c_mis = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [1:0] kind);
        drive(1'b1, rd, kind, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic m, input logic [31:0] tg);
        drive(1'b0, 5'h0, 2'd0, 1'b1, t, v, m, tg);
    endtask

    task automatic idle();
        drive(1'b0, 5'h0, 2'd0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        d_en = 1'b0; d_rd = 5'h0; d_kind = 2'd0; qs = 4'h0; qt = 4'h0;
        c_en = 1'b0; c_tag = 4'h0; c_val = 32'h0; c_mis = 1'b0; c_tgt = 32'h0;
        #3;
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_tag", 32'(tag), 32'h0);
        chk("rst_rf_en", 32'(rf_en), 32'h0);
        chk("rst_rf_value", rf_val, 32'h0);
        chk("rst_rf_rst", 32'(rf_rst), 32'h0);
        chk("rst_lsb", 32'(lsb_c), 32'h0);
        chk("rst_flush", 32'(fl), 32'h0);
        chk("rst_pc", fl_pc, 32'h0);
        m_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    int cnt;
    int cand[$];

    initial begin
        // 1: directed table -- three ALU allocs, out-of-order CDB, in-order commit
        tv[0] = '{1'b1, 5'd1, 1'b0, 4'h0, 32'h0,  4'd0, 1'b0, 5'd0, 32'h0,  4'd0};
        tv[1] = '{1'b1, 5'd2, 1'b0, 4'h0, 32'h0,  4'd1, 1'b0, 5'd0, 32'h0,  4'd0};
        tv[2] = '{1'b1, 5'd3, 1'b0, 4'h0, 32'h0,  4'd2, 1'b0, 5'd0, 32'h0,  4'd0};
        tv[3] = '{1'b0, 5'd0, 1'b1, 4'h1, 32'h22, 4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
        tv[4] = '{1'b0, 5'd0, 1'b1, 4'h0, 32'h11, 4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
        tv[5] = '{1'b0, 5'd0, 1'b0, 4'h0, 32'h0,  4'd3, 1'b1, 5'd1, 32'h11, 4'd0};
        tv[6] = '{1'b0, 5'd0, 1'b0, 4'h0, 32'h0,  4'd3, 1'b1, 5'd2, 32'h22, 4'd1};
        tv[7] = '{1'b0, 5'd0, 1'b0, 4'h0, 32'h0,  4'd3, 1'b0, 5'd2, 32'h22, 4'd1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tv[i].en, tv[i].rd, 2'd0, tv[i].ce, tv[i].ct, tv[i].cv, 1'b0, 32'h0);
            chk($sformatf("tv%0d_tag", i), 32'(pre_tag), 32'(tv[i].exp_tag));
            chk($sformatf("tv%0d_rf_en", i), 32'(rf_en), 32'(tv[i].exp_rf_en));
            chk($sformatf("tv%0d_rf_d", i), 32'(rf_d), 32'(tv[i].exp_d));
            chk($sformatf("tv%0d_rf_value", i), rf_val, tv[i].exp_val);
            chk($sformatf("tv%0d_rf_h", i), 32'(rf_h), 32'(tv[i].exp_h));
        end

        // 2: fill to 16, wrap, drop 17th, drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i + 1), 2'd0);
            chk("t2_tag", 32'(pre_tag), 32'(i));
        end
        alloc(5'd9, 2'd0);
        chk("t2_full", 32'(pre_full), 32'h1);
        chk("t2_tag_wrap", 32'(pre_tag), 32'h0);
        cnt = 0;
        for (int i = 15; i >= 0; i--) begin
            cdb(4'(i), 32'(32'h1000 + i), 1'b0, 32'h0);
            if (rf_en) cnt++;
        end
        for (int i = 0; i < 24; i++) begin
            idle();
            if (rf_en) cnt++;
        end
        chk("t2_commits", 32'(cnt), 32'd16);
        chk("t2_empty_full", 32'(pre_full), 32'h0);

        // 3a: alloc while full coincides with a commit -> dropped
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'd4, 2'd0);
        cdb(4'h0, 32'h30, 1'b0, 32'h0);
        alloc(5'd9, 2'd0);
        chk("t3_full_pre", 32'(pre_full), 32'h1);
        chk("t3_commit_h", 32'(rf_h), 32'h0);
        idle();
        chk("t3_after_full", 32'(pre_full), 32'h0);
        chk("t3_after_tag", 32'(pre_tag), 32'h0);
        // 3b: alloc + commit at count 5 keeps count at 5
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'd6, 2'd0);
        cdb(4'h0, 32'h40, 1'b0, 32'h0);
        alloc(5'd7, 2'd0);
        chk("t3b_tag", 32'(pre_tag), 32'd5);
        chk("t3b_commit", 32'(rf_en), 32'h1);
        for (int i = 0; i < 11; i++) begin
            alloc(5'd8, 2'd0);
            chk("t3b_not_full", 32'(pre_full), 32'h0);
        end
        idle();
        chk("t3b_full", 32'(pre_full), 32'h1);

        // 4: query bypass from the CDB
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'd1, 2'd0);
        qs = 4'd4; qt = 4'd3;
        cdb(4'd4, 32'hABCD, 1'b0, 32'h0);
        chk("t4_qs_ready", 32'(pre_qs_rdy), 32'h1);
        chk("t4_qs_value", pre_qs_val, 32'hABCD);
        chk("t4_qt_ready", 32'(pre_qt_rdy), 32'h0);
        chk("t4_qt_value", pre_qt_val, 32'h0);
        idle();
        chk("t4_qs_held", pre_qs_val, 32'hABCD);
        qs = 4'd0; qt = 4'd0;

        // 5: mispredicted branch at head flushes younger ready entries
        do_reset();
        alloc(5'd1, 2'd1);
        alloc(5'd2, 2'd0);
        alloc(5'd3, 2'd0);
        alloc(5'd4, 2'd0);
        cdb(4'd1, 32'h21, 1'b0, 32'h0);
        cdb(4'd2, 32'h22, 1'b0, 32'h0);
        cdb(4'd3, 32'h23, 1'b0, 32'h0);
        cdb(4'd0, 32'h4, 1'b1, 32'h100);
        idle();
        chk("t5_rf_en", 32'(rf_en), 32'h1);
        chk("t5_rf_d", 32'(rf_d), 32'h1);
        chk("t5_link", rf_val, 32'h4);
        chk("t5_no_flush_yet", 32'(fl), 32'h0);
        idle();
        chk("t5_full_in_flush", 32'(pre_full), 32'h1);
        chk("t5_rst", 32'(rf_rst), 32'h1);
        chk("t5_flush", 32'(fl), 32'h1);
        chk("t5_pc", fl_pc, 32'h100);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (rf_en) cnt++;
        end
        chk("t5_no_young_commit", 32'(cnt), 32'h0);
        chk("t5_tag0", 32'(pre_tag), 32'h0);
        chk("t5_flush_drop", 32'(fl), 32'h0);

        // 6: store commit, rdy_in freeze, reset mid-commit
        do_reset();
        alloc(5'd0, 2'd2);
        alloc(5'd5, 2'd0);
        alloc(5'd6, 2'd0);
        cdb(4'd0, 32'h77, 1'b0, 32'h0);
        cdb(4'd1, 32'h55, 1'b0, 32'h0);
        chk("t6_lsb", 32'(lsb_c), 32'h1);
        chk("t6_lsb_tag", 32'(lsb_tag), 32'h0);
        chk("t6_no_rf", 32'(rf_en), 32'h0);
        cdb(4'd2, 32'h66, 1'b0, 32'h0);
        chk("t6_rf_d5", 32'(rf_d), 32'd5);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_hold_en", 32'(rf_en), 32'h1);
            chk("t6_hold_d", 32'(rf_d), 32'd5);
        end
        rdy_in = 1'b1;
        idle();
        chk("t6_rf_d6", 32'(rf_d), 32'd6);
        chk("t6_rf_v", rf_val, 32'h66);
        idle();
        chk("t6_idle_en", 32'(rf_en), 32'h0);
        chk("t6_tag3", 32'(pre_tag), 32'd3);
        alloc(5'd7, 2'd0);
        cdb(4'd3, 32'h99, 1'b0, 32'h0);
        idle();
        chk("t6_pre_rst_en", 32'(rf_en), 32'h1);
        rst_in = 1'b1;
        #1;
        chk("t6_async_rst_en", 32'(rf_en), 32'h0);
        chk("t6_async_rst_tag", 32'(tag), 32'h0);

        // randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            d_en   = ($urandom_range(0, 2) != 0);
            d_rd   = 5'($urandom);
            d_kind = 2'($urandom_range(0, 2));
            cand.delete();
            foreach (m_q[i]) if (!m_q[i].ready) cand.push_back(m_q[i].tag);
            if (cand.size() > 0 && $urandom_range(0, 9) < 7) begin
                c_en  = 1'b1;
                c_tag = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                c_val = $urandom;
                c_mis = ($urandom_range(0, 11) == 0);
                c_tgt = $urandom;
            end else begin
                c_en = 1'b0; c_mis = 1'b0;
            end
            qs = 4'($urandom);
            qt = 4'($urandom);
            cycle();
        end
        rdy_in = 1'b1;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
